// File: rtl/mixcolumns_engine.sv
// AES MixColumns / InvMixColumns engine: one 128-bit block per handshake,
// COLS_PER_CYCLE columns transformed in place per clock.
module mixcolumns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 4,
    parameter bit          OUT_REG        = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int unsigned NCOL = 4;
    // Column index of the final group handled in BUSY
    localparam logic [2:0]  LAST = 3'(NCOL - COLS_PER_CYCLE);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t       state, state_nx;
    logic [1:0]   col, col_nx;
    logic [127:0] work, work_nx, work_mix;
    logic         inv_q, inv_nx;
    logic         in_ready_q, out_valid_q, busy_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv_mode);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        // Row i uses a[i..i+3] against the rotated coefficient row
        for (int i = 0; i < 4; i++) begin
            if (inv_mode)
                r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                               ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                               ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                               ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            else
                r[31-8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4]
                               ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

    // Column c lives at bits [127-32c -: 32]; 127-32c == {~c, 5'h1f}
    always_comb begin
        work_mix = work;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            work_mix[{~(col + 2'(k)), 5'h1f} -: 32] =
                mix_col(work[{~(col + 2'(k)), 5'h1f} -: 32], inv_q);
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        work_nx  = work;
        inv_nx   = inv_q;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_nx = S_BUSY;
                    work_nx  = state_in;
                    inv_nx   = inv;
                    col_nx   = '0;
                end
            end
            S_BUSY: begin
                work_nx = work_mix;
                if ({1'b0, col} == LAST) state_nx = S_DONE;
                else                     col_nx   = col + 2'(COLS_PER_CYCLE);
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                    col_nx   = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            col         <= '0;
            work        <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            work        <= work_nx;
            inv_q       <= inv_nx;
            in_ready_q  <= (state_nx == S_IDLE);
            out_valid_q <= (state_nx == S_DONE);
            busy_q      <= (state_nx != S_IDLE);
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [127:0] out_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                                       out_q <= '0;
                else if (state == S_BUSY && state_nx == S_DONE) out_q <= work_mix;
            end
            assign state_out = out_q;
        end else begin : g_out_inplace
            assign state_out = work;
        end
    endgenerate

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mixcolumns_engine.sv
// Scoreboard bench for mixcolumns_engine: three instances (4, 1 and 2 columns per cycle)
// driven with directed vectors plus a forward/inverse round trip.
module tb_mixcolumns_engine;

    localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] D4_IN  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] D4_OUT = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         inv_in    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];
    logic         busy      [3];

    logic [127:0] expq [3][$];
    int           cols [3] = '{4, 1, 2};
    int           checks = 0;
    int           errors = 0;

    mixcolumns_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1'b1)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .state_in(state_in[0]), .inv(inv_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .state_out(state_out[0]), .busy(busy[0]));

    mixcolumns_engine #(.COLS_PER_CYCLE(1), .OUT_REG(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .state_in(state_in[1]), .inv(inv_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .state_out(state_out[1]), .busy(busy[1]));

    mixcolumns_engine #(.COLS_PER_CYCLE(2), .OUT_REG(1'b1)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .state_in(state_in[2]), .inv(inv_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .state_out(state_out[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference GF(2^8) multiply by shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit iv);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (iv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else    begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127-32*c-8*j -: 8], m[(j - row + 4) % 4]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    // Present a block, push its expected result, optionally measure latency
    task automatic send(input int i, input logic [127:0] d, input bit iv, input logic [127:0] e,
                        input bit lat, input bit keep);
        int n;
        @(negedge clk);
        in_valid[i] = 1'b1; state_in[i] = d; inv_in[i] = iv;
        n = 0;
        while (!in_ready[i] && n < 100) begin @(negedge clk); n++; end
        if (!in_ready[i]) begin
            chk(1'b0, "accept_timeout", 128'(i), 128'(1));
            in_valid[i] = 1'b0;
            return;
        end
        expq[i].push_back(e);
        @(posedge clk); #1;
        if (!keep) in_valid[i] = 1'b0;
        if (lat) begin
            n = 0;
            while (!out_valid[i] && n < 20) begin @(posedge clk); #1; n++; end
            chk(n == 4 / cols[i], "latency", 128'(n), 128'(4 / cols[i]));
            chk(busy[i] === 1'b1, "busy_in_done", 128'(busy[i]), 128'(1));
        end
    endtask

    initial begin
        logic [127:0] x, y;
        int n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; state_in[i] = '0; inv_in[i] = 1'b0; out_ready[i] = 1'b1;
        end
        fork
            begin : monitor
                logic [127:0] ev;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < 3; i++) begin
                        if (!rst && out_valid[i] && out_ready[i]) begin
                            if (expq[i].size() == 0) begin
                                chk(1'b0, "unexpected_output", state_out[i], '0);
                            end else begin
                                ev = expq[i].pop_front();
                                chk(state_out[i] === ev, "state_out", state_out[i], ev);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    chk(in_ready[i] === 1'b0, "rst_in_ready", 128'(in_ready[i]), '0);
                    chk(out_valid[i] === 1'b0, "rst_out_valid", 128'(out_valid[i]), '0);
                    chk(busy[i] === 1'b0, "rst_busy", 128'(busy[i]), '0);
                end
                chk(state_out[0] === '0, "rst_state_out0", state_out[0], '0);
                chk(state_out[2] === '0, "rst_state_out2", state_out[2], '0);
                rst = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < 3; i++)
                    chk(in_ready[i] === 1'b1, "idle_in_ready", 128'(in_ready[i]), 128'(1));

                // Forward on 4-wide, inverse on 1-wide, known column on 2-wide
                send(0, T1_IN, 1'b0, T1_OUT, 1'b1, 1'b0);
                send(1, T1_OUT, 1'b1, T1_IN, 1'b1, 1'b0);
                send(2, D4_IN, 1'b0, D4_OUT, 1'b1, 1'b0);
                send(2, D4_OUT, 1'b1, D4_IN, 1'b1, 1'b0);

                for (int k = 0; k < 1000; k++) begin
                    x = {$urandom, $urandom, $urandom, $urandom};
                    y = ref_mix(x, 1'b0);
                    send(2, x, 1'b0, y, 1'b0, 1'b0);
                    send(2, y, 1'b1, x, 1'b0, 1'b0);
                end

                // Backpressure with junk on the input side
                out_ready[0] = 1'b0;
                send(0, T1_IN, 1'b0, T1_OUT, 1'b1, 1'b0);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk(out_valid[0] === 1'b1, "bp_out_valid", 128'(out_valid[0]), 128'(1));
                    chk(state_out[0] === T1_OUT, "bp_state_out", state_out[0], T1_OUT);
                    chk(in_ready[0] === 1'b0, "bp_in_ready", 128'(in_ready[0]), '0);
                    in_valid[0] = k[0]; inv_in[0] = ~k[0];
                    state_in[0] = {$urandom, $urandom, $urandom, $urandom};
                end
                @(posedge clk); #1;
                in_valid[0] = 1'b0; out_ready[0] = 1'b1;
                @(posedge clk); #1;
                chk(in_ready[0] === 1'b1, "bp_release_in_ready", 128'(in_ready[0]), 128'(1));
                chk(out_valid[0] === 1'b0, "bp_release_out_valid", 128'(out_valid[0]), '0);

                // Reset while the 1-wide instance is at column 2
                @(negedge clk);
                chk(in_ready[1] === 1'b1, "pre_abort_ready", 128'(in_ready[1]), 128'(1));
                in_valid[1] = 1'b1; state_in[1] = D4_IN; inv_in[1] = 1'b0;
                @(posedge clk); #1;
                in_valid[1] = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                chk(out_valid[1] === 1'b0, "abort_out_valid", 128'(out_valid[1]), '0);
                chk(busy[1] === 1'b0, "abort_busy", 128'(busy[1]), '0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                chk(in_ready[1] === 1'b1, "abort_in_ready", 128'(in_ready[1]), 128'(1));
                chk(out_valid[1] === 1'b0, "abort_idle_out_valid", 128'(out_valid[1]), '0);
                send(1, T1_IN, 1'b0, T1_OUT, 1'b1, 1'b0);

                // Back-to-back modes with in_valid held high
                send(2, D4_IN, 1'b0, D4_OUT, 1'b0, 1'b1);
                send(2, T1_OUT, 1'b1, T1_IN, 1'b0, 1'b1);
                in_valid[2] = 1'b0;

                n = 0;
                while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 200) begin
                    @(posedge clk); n++;
                end
                chk((expq[0].size() + expq[1].size() + expq[2].size()) == 0, "drain",
                    128'(expq[0].size() + expq[1].size() + expq[2].size()), '0);
                repeat (2) @(posedge clk);
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
